// File: rtl/multdiv_unit.sv
// multdiv_unit: iterative signed WIDTH-bit multiply/divide unit for the
// execute stage. Operands come from the register file read ports and the
// result goes back through the write port.
//   Multiply: radix-2 shift-add over the multiplier bits. The partial product
//             for the multiplier sign bit is subtracted on the final step,
//             which gives that bit its negative two's-complement weight.
//   Divide:   non-restoring divide on operand magnitudes. The quotient sign
//             is applied when the result is written.
// Optional build macro MULTDIV_EARLY_ZERO_EN: operations with a zero operand
// finish after one iteration instead of WIDTH. Results are the same either way.
module multdiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             ctrl_reset_n,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCount = CntW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MostNeg = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} stateType;

  stateType           state;
  logic [CntW-1:0]    count;

  // Multiply datapath: product accumulator, left-shifting multiplicand,
  // right-shifting multiplier.
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;

  // Divide datapath: signed partial remainder, dividend/quotient shift
  // register, and divisor magnitude.
  logic [WIDTH+1:0]   rem;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   divisorMag;
  logic               negateQuot;
  logic               divByZero;
  logic               divOverflow;
  logic               earlyZero;

  logic               start;
  logic               lastIter;
  logic [WIDTH-1:0]   magA;
  logic [WIDTH-1:0]   magB;
  logic               startDivZero;
  logic               startDivOverflow;
  logic [2*WIDTH-1:0] mulAddend;
  logic [2*WIDTH-1:0] accNext;
  logic               mulOverflow;
  logic [WIDTH+1:0]   remShift;
  logic [WIDTH+1:0]   remNext;
  logic [WIDTH-1:0]   quotNext;
  logic [WIDTH-1:0]   quotSigned;

  // Start decode and operand preprocessing, only meaningful on the start edge.
  // Both ctrl lines high together is not a start.
  always_comb begin
    start            = ctrl_MULT ^ ctrl_DIV;
    magA             = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    magB             = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    startDivZero     = (data_operandB == '0);
    startDivOverflow = (data_operandA == MostNeg) && (data_operandB == '1);
  end

  // One multiply step and one non-restoring divide step. Each is computed
  // from the current registers.
  always_comb begin
    lastIter  = (count == LastCount);
    mulAddend = '0;
    if (mplier[0]) begin
      mulAddend = lastIter ? -mcand : mcand;
    end
    accNext     = acc + mulAddend;
    mulOverflow = (accNext[2*WIDTH-1:WIDTH] != {WIDTH{accNext[WIDTH-1]}});
    remShift    = {rem[WIDTH:0], quot[WIDTH-1]};
    remNext     = rem[WIDTH+1] ? (remShift + {2'b00, divisorMag})
                               : (remShift - {2'b00, divisorMag});
    quotNext    = {quot[WIDTH-2:0], ~remNext[WIDTH+1]};
    quotSigned  = negateQuot ? -quotNext : quotNext;
  end

`ifndef MULTDIV_EARLY_ZERO_EN
  assign earlyZero = 1'b0;
`endif

  // Control FSM and datapath registers. A valid start in any state restarts
  // the operation. Result outputs change only when entering DONE.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state          <= IDLE;
      count          <= '0;
      acc            <= '0;
      mcand          <= '0;
      mplier         <= '0;
      rem            <= '0;
      quot           <= '0;
      divisorMag     <= '0;
      negateQuot     <= 1'b0;
      divByZero      <= 1'b0;
      divOverflow    <= 1'b0;
`ifdef MULTDIV_EARLY_ZERO_EN
      earlyZero      <= 1'b0;
`endif
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else if (start) begin
      state          <= ctrl_MULT ? MUL : DIV;
      count          <= '0;
      acc            <= '0;
      mcand          <= {{WIDTH{data_operandA[WIDTH-1]}}, data_operandA};
      mplier         <= data_operandB;
      rem            <= '0;
      quot           <= magA;
      divisorMag     <= magB;
      negateQuot     <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      divByZero      <= startDivZero;
      divOverflow    <= startDivOverflow;
`ifdef MULTDIV_EARLY_ZERO_EN
      earlyZero      <= (data_operandA == '0) || (data_operandB == '0);
`endif
      data_resultRDY <= 1'b0;
      busy           <= 1'b1;
    end else begin
      case (state)
        MUL: begin
          count  <= count + 1'b1;
          acc    <= accNext;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          if (lastIter || earlyZero) begin
            state          <= DONE;
            busy           <= 1'b0;
            data_resultRDY <= 1'b1;
            data_result    <= earlyZero ? '0 : accNext[WIDTH-1:0];
            data_exception <= earlyZero ? 1'b0 : mulOverflow;
          end
        end
        DIV: begin
          count <= count + 1'b1;
          rem   <= remNext;
          quot  <= quotNext;
          if (lastIter || earlyZero) begin
            state          <= DONE;
            busy           <= 1'b0;
            data_resultRDY <= 1'b1;
            if (divByZero) begin
              data_result    <= '0;
              data_exception <= 1'b1;
            end else if (divOverflow) begin
              data_result    <= MostNeg;
              data_exception <= 1'b1;
            end else if (earlyZero) begin
              data_result    <= '0;
              data_exception <= 1'b0;
            end else begin
              data_result    <= quotSigned;
              data_exception <= 1'b0;
            end
          end
        end
        DONE: begin
          state          <= IDLE;
          data_resultRDY <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
